util_cdc_handshake_tx: RTL and testbench

Source-side sender of a four-phase req/ack clock-domain crossing. It accepts a WIDTH-bit word via a valid/ready handshake in the local clock domain. It drives a registered, stable data bus plus a level request toward a foreign domain. The foreign domain returns an asynchronous acknowledge, which this block synchronizes internally with a multi-flop chain. It pairs with the destination-side synchronizing receiver in the util library.

---
 rtl/util_cdc_handshake_tx.sv | 151 +++++++++++++++
 tb/tb_util_cdc_handshake_tx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/util_cdc_handshake_tx.sv
// Source side of a four-phase req/ack clock-domain crossing with an internally synchronized ack.
// Optional sticky stall timeout: define UTIL_CDC_HANDSHAKE_TX_TIMEOUT_EN.
module util_cdc_handshake_tx #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             cdc_req_o,
    output logic [WIDTH-1:0] cdc_data_o,
    input  logic             cdc_ack_i,
    output logic             timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("util_cdc_handshake_tx: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_cdc_req;
    logic                   w_req_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   w_load;
    logic [WIDTH-1:0]       r_cdc_data;

    // Multi-flop synchronizer on the foreign-domain acknowledge
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], cdc_ack_i};
        end
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_cdc_req <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cdc_req <= w_req_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Data is only loaded on accept, so it stays stable through REQ and RELEASE
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cdc_data <= '0;
        end else if (w_load) begin
            r_cdc_data <= data_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_cdc_req;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_nxt = 1'b0;
                if (valid_i) begin
                    w_load      = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_req_nxt = 1'b1;
                if (w_ack_s) begin
                    w_req_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_req_nxt = 1'b0;
                if (!w_ack_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ready_o    = (r_state == ST_IDLE);
    assign done_o     = r_done;
    assign cdc_req_o  = r_cdc_req;
    assign cdc_data_o = r_cdc_data;

`ifdef UTIL_CDC_HANDSHAKE_TX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             r_timeout;

    // Counts cycles spent in the current waiting state; restarts on any state change
    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if (w_state_nxt != r_state) begin
            w_wait_cnt_nxt = '0;
        end else if (r_state != ST_IDLE && r_wait_cnt != CNT_MAX) begin
            w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
            if (r_state != ST_IDLE && w_wait_cnt_nxt == CNT_MAX) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_util_cdc_handshake_tx.sv
// Randomized bench for util_cdc_handshake_tx against a transaction-level handshake model,
// plus directed literal checks of latency, reset, stuck-ack and timeout behaviour.
module tb_util_cdc_handshake_tx;

    localparam int unsigned W  = 32;
    localparam int unsigned S  = 2;
    localparam int unsigned T  = 16;
`ifdef UTIL_CDC_HANDSHAKE_TX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         valid_i;
    logic [W-1:0] data_i;
    logic         ready_o;
    logic         done_o;
    logic         cdc_req_o;
    logic [W-1:0] cdc_data_o;
    logic         cdc_ack_w;
    logic         timeout_o;

    logic         loop_mode;
    logic         tb_ack;

    assign cdc_ack_w = loop_mode ? cdc_req_o : tb_ack;

    always #5 clk_i = ~clk_i;

    util_cdc_handshake_tx #(
        .WIDTH         (W),
        .SYNC_STAGES   (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .done_o    (done_o),
        .cdc_req_o (cdc_req_o),
        .cdc_data_o(cdc_data_o),
        .cdc_ack_i (cdc_ack_w),
        .timeout_o (timeout_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int dut_done_cnt = 0;

    // Reference: a transfer is "busy" from accept until the far ack (seen S edges late)
    // has gone high and back low; the request is up only until the delayed ack is seen high.
    bit           m_busy    = 1'b0;
    bit           m_req     = 1'b0;
    bit           m_done    = 1'b0;
    bit           m_timeout = 1'b0;
    logic [W-1:0] m_data    = '0;
    int           m_phase_cycles = 0;
    int           m_acc_cnt = 0;
    int           m_acc_cyc[$];
    bit           m_hist[$];

    always @(posedge clk_i) begin
        bit ack_late;
        bit dummy;
        cyc++;
        if (reset_i) begin
            m_busy = 0; m_req = 0; m_done = 0; m_timeout = 0;
            m_data = '0; m_phase_cycles = 0;
            m_hist.delete();
            for (int i = 0; i < int'(S); i++) m_hist.push_back(1'b0);
        end else begin
            ack_late = m_hist[S-1];
            m_hist.push_front(cdc_ack_w);
            dummy = m_hist.pop_back();
            m_done = 0;
            if (!m_busy) begin
                if (valid_i) begin
                    m_busy = 1; m_req = 1; m_data = data_i; m_phase_cycles = 0;
                    m_acc_cnt++;
                    m_acc_cyc.push_back(cyc);
                end
            end else if (m_req) begin
                if (ack_late) begin
                    m_req = 0; m_done = 1; m_phase_cycles = 0;
                end else begin
                    m_phase_cycles++;
                end
            end else begin
                if (!ack_late) begin
                    m_busy = 0; m_phase_cycles = 0;
                end else begin
                    m_phase_cycles++;
                end
            end
            if (TO_EN && m_busy && m_phase_cycles >= int'(T)) m_timeout = 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk_i);
            if (!reset_i) begin
                chk("ready_o",    64'(ready_o),    64'(!m_busy));
                chk("cdc_req_o",  64'(cdc_req_o),  64'(m_req));
                chk("cdc_data_o", 64'(cdc_data_o), 64'(m_data));
                chk("done_o",     64'(done_o),     64'(m_done));
                chk("timeout_o",  64'(timeout_o),  64'(m_timeout));
                if (done_o) dut_done_cnt++;
            end
        end
    endtask

    task automatic wait_ready(input string nm, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (ready_o) begin ok = 1; break; end
        end
        chk(nm, 64'(ok), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int base;
        bit ok;
        logic [W-1:0] held;

        reset_i = 1'b1; valid_i = 1'b0; data_i = '0; loop_mode = 1'b1; tb_ack = 1'b0;
        fork
            compare_loop();
        join_none

        repeat (3) @(negedge clk_i);
        chk("rst_req",     64'(cdc_req_o),  64'd0);
        chk("rst_data",    64'(cdc_data_o), 64'd0);
        chk("rst_done",    64'(done_o),     64'd0);
        chk("rst_timeout", 64'(timeout_o),  64'd0);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", 64'(ready_o), 64'd1);

        // Loopback latency with a single word
        valid_i = 1'b1; data_i = 32'hDEADBEEF;
        @(posedge clk_i); #1;
        chk("t1_data", 64'(cdc_data_o), 64'hDEADBEEF);
        chk("t1_req",  64'(cdc_req_o),  64'd1);
        @(negedge clk_i);
        valid_i = 1'b0; data_i = $urandom;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk_i); #1;
            if (k < 3) begin
                chk("t1_req_hold", 64'(cdc_req_o), 64'd1);
                chk("t1_no_done",  64'(done_o),    64'd0);
            end
            if (k == 3) begin
                chk("t1_req_fall", 64'(cdc_req_o), 64'd0);
                chk("t1_done",     64'(done_o),    64'd1);
            end
            if (k == 5) chk("t1_not_ready", 64'(ready_o), 64'd0);
            if (k == 6) chk("t1_ready",     64'(ready_o), 64'd1);
        end

        // Back-to-back words under loopback with valid held high
        @(negedge clk_i);
        dut_done_cnt = 0;
        base = m_acc_cnt;
        valid_i = 1'b1; data_i = 32'd1;
        for (int w = 1; w <= 3; w++) begin
            ok = 0;
            for (int i = 0; i < 40; i++) begin
                if (m_acc_cnt >= base + w) begin ok = 1; break; end
                @(negedge clk_i);
            end
            chk("t2_accept", 64'(ok), 64'd1);
            data_i = W'(w + 1);
            if (w == 3) valid_i = 1'b0;
        end
        wait_ready("t2_ready", 20);
        chk("t2_done_pulses", 64'(dut_done_cnt), 64'd3);
        // ready rises 2*(S+1) edges after an accept; the next accept lands on the following edge
        for (int i = 1; i <= 2; i++)
            chk("t2_spacing", 64'(m_acc_cyc[m_acc_cyc.size()-i] - m_acc_cyc[m_acc_cyc.size()-i-1]),
                64'(2 * (S + 1) + 1));

        // Delayed ack from a slow far side, data_i wiggling mid-transfer
        loop_mode = 1'b0; tb_ack = 1'b0;
        valid_i = 1'b1; data_i = 32'hA5A5_0F0F; held = 32'hA5A5_0F0F;
        @(posedge clk_i);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            valid_i = 1'($urandom); data_i = $urandom;
        end
        valid_i = 1'b0;
        tb_ack = 1'b1;
        repeat (2) begin @(posedge clk_i); #1; chk("t3_no_done_yet", 64'(done_o), 64'd0); end
        @(posedge clk_i); #1;
        chk("t3_done",      64'(done_o),     64'd1);
        chk("t3_data_held", 64'(cdc_data_o), 64'(held));
        repeat (15) @(negedge clk_i);
        tb_ack = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; chk("t3_wait_release", 64'(ready_o), 64'd0); end
        @(posedge clk_i); #1;
        chk("t3_ready", 64'(ready_o), 64'd1);

        // Reset while the request is up
        @(negedge clk_i);
        valid_i = 1'b1; data_i = 32'h1234_5678;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        #1;
        chk("t4_req_drop",  64'(cdc_req_o),  64'd0);
        chk("t4_data_drop", 64'(cdc_data_o), 64'd0);
        chk("t4_done_drop", 64'(done_o),     64'd0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("t4_ready", 64'(ready_o), 64'd1);
        loop_mode = 1'b1;
        dut_done_cnt = 0;
        valid_i = 1'b1; data_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        valid_i = 1'b0;
        wait_ready("t4_recover", 20);
        chk("t4_done_after", 64'(dut_done_cnt), 64'd1);

        // Ack never returned: timeout (feature-dependent)
        loop_mode = 1'b0; tb_ack = 1'b0;
        valid_i = 1'b1; data_i = 32'h0BAD_0BAD;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        valid_i = 1'b0;
        for (int k = 1; k <= int'(T); k++) begin
            @(posedge clk_i); #1;
            if (k == int'(T) - 1) chk("t5_no_timeout_yet", 64'(timeout_o), 64'd0);
            if (k == int'(T))     chk("t5_timeout",        64'(timeout_o), 64'(TO_EN));
        end
        repeat (10) @(negedge clk_i);
        chk("t5_timeout_sticky", 64'(timeout_o), 64'(TO_EN));
        do_reset();

        // Far-side ack already high while idle
        tb_ack = 1'b1;
        repeat (4) @(negedge clk_i);
        valid_i = 1'b1; data_i = 32'h5555_AAAA;
        @(posedge clk_i); #1;
        chk("t6_req", 64'(cdc_req_o), 64'd1);
        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("t6_done",     64'(done_o),    64'd1);
        chk("t6_req_fall", 64'(cdc_req_o), 64'd0);
        repeat (10) @(negedge clk_i);
        chk("t6_stuck", 64'(ready_o), 64'd0);
        tb_ack = 1'b0;
        wait_ready("t6_ready", 10);
        do_reset();

        // Random traffic under loopback and a randomly toggling far-side ack
        for (int seg = 0; seg < 12; seg++) begin
            loop_mode = 1'($urandom);
            for (int i = 0; i < 200; i++) begin
                valid_i = ($urandom_range(0, 2) == 0);
                data_i  = $urandom;
                if ($urandom_range(0, 5) == 0) tb_ack = ~tb_ack;
                @(negedge clk_i);
            end
        end
        valid_i = 1'b0; loop_mode = 1'b1;
        repeat (20) @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
